// File: rtl/cam_result_collector.sv
// Packs single-bit CAM match results LSB-first into wide words and streams them
// out through a first-word-fall-through FIFO, with TLAST framing, match count and sticky overflow.
module cam_result_collector #(
  parameter int C_DATA_WIDTH = 512,
  parameter int OUT_WIDTH    = 512,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = $clog2(OUT_WIDTH) + 1
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [OUT_WIDTH-1:0]    m_tdata,
  output logic [CNT_WIDTH-1:0]    m_tcount,
  output logic                    m_tlast,
  output logic [31:0]             match_total,
  output logic                    overflow
);

  localparam int PW = $clog2(OUT_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [3:0] ST_SEARCH_ONE = 4'h4;
  localparam logic [3:0] ST_SEARCH_MQ  = 4'h5;
  localparam logic [3:0] ST_EOS        = 4'hF;

  localparam logic PACK = 1'b0;
  localparam logic EMIT = 1'b1;

  typedef struct packed {
    logic [OUT_WIDTH-1:0] data;
    logic [CNT_WIDTH-1:0] count;
    logic                 last;
  } word_t;

  logic                 state_q, state_d;
  logic [OUT_WIDTH-1:0] pack_q, pack_d, res_word;
  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
  word_t                pq_q [2];
  word_t                pq_d [2];
  logic [1:0]           pq_cnt_q, pq_cnt_d;
  logic [31:0]          total_q, total_d;
  logic                 overflow_q, overflow_d;
  word_t                mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          fcnt_q, fcnt_d;

  logic [3:0] st;
  logic       is_res, is_eos, last_bit, enq, push, pop, full, wr_en;
  word_t      enq_word, push_word, head;
  logic       unused_bits;

  assign unused_bits = ^s_tdata[C_DATA_WIDTH-5:1];

  assign st       = s_tdata[C_DATA_WIDTH-1 -: 4];
  assign is_res   = s_tvalid && (st == ST_SEARCH_ONE || st == ST_SEARCH_MQ);
  assign is_eos   = s_tvalid && (st == ST_EOS);
  assign last_bit = (pcnt_q == CNT_WIDTH'(OUT_WIDTH - 1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res_word                  = pack_q;
    res_word[pcnt_q[PW-1:0]]  = s_tdata[0];
    pack_d   = pack_q;
    pcnt_d   = pcnt_q;
    enq      = 1'b0;
    enq_word = '0;
    if (is_res) begin
      if (last_bit) begin
        // Word completes: hand it off and restart packing in the same cycle, so no gap.
        enq      = 1'b1;
        enq_word = '{data: res_word, count: CNT_WIDTH'(OUT_WIDTH), last: 1'b0};
        pack_d   = '0;
        pcnt_d   = '0;
      end else begin
        pack_d = res_word;
        pcnt_d = pcnt_q + CNT_WIDTH'(1);
      end
    end else if (is_eos) begin
      enq      = 1'b1;
      enq_word = '{data: pack_q, count: pcnt_q, last: 1'b1};
      pack_d   = '0;
      pcnt_d   = '0;
    end
  end

  // Pending-push queue: the head is pushed every EMIT cycle, new words append behind it.
  assign push      = (state_q == EMIT);
  assign push_word = pq_q[0];

  // NOTE: blocking assignments here are intentional; pq_cnt_d is read back after its own update.
  always_comb begin
    pq_d     = pq_q;
    pq_cnt_d = pq_cnt_q;
    if (push) begin
      pq_d[0]  = pq_q[1];
      pq_cnt_d = pq_cnt_q - 2'd1;
    end
    if (enq) begin
      pq_d[pq_cnt_d[0]] = enq_word;
      pq_cnt_d          = pq_cnt_d + 2'd1;
    end
    state_d = (pq_cnt_d != 2'd0) ? EMIT : PACK;
  end

  assign full     = (fcnt_q == (AW+1)'(FIFO_DEPTH));
  assign m_tvalid = (fcnt_q != '0);
  assign pop      = m_tvalid && m_tready;
  assign wr_en    = push && (!full || pop);
  assign wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

  always_comb begin
    unique case ({wr_en, pop})
      2'b10:   fcnt_d = fcnt_q + (AW+1)'(1);
      2'b01:   fcnt_d = fcnt_q - (AW+1)'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  assign overflow_d = overflow_q | (push && full && !pop);

  // Clear on the cycle after a last word is pushed, whether or not the FIFO kept it.
  always_comb begin
    total_d = (push && push_word.last) ? 32'd0 : total_q;
    if (is_res && s_tdata[0] && total_d != 32'hFFFF_FFFF) begin
      total_d = total_d + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= PACK;
      pack_q     <= '0;
      pcnt_q     <= '0;
      pq_cnt_q   <= '0;
      total_q    <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pack_q     <= pack_d;
      pcnt_q     <= pcnt_d;
      pq_cnt_q   <= pq_cnt_d;
      total_q    <= total_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // NOTE: storage is not reset; occupancy counters qualify it and outputs are gated while empty.
  always_ff @(posedge aclk) begin
    pq_q <= pq_d;
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign m_tdata     = m_tvalid ? head.data  : '0;
  assign m_tcount    = m_tvalid ? head.count : '0;
  assign m_tlast     = m_tvalid ? head.last  : 1'b0;
  assign match_total = total_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cam_result_collector.sv
// Scoreboard bench for cam_result_collector: expected words are queued as stimulus
// is driven and compared by a monitor on every output handshake.
module tb_cam_result_collector;

  localparam int DW = 512;
  localparam int OW = 512;
  localparam int CW = $clog2(OW) + 1;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [CW-1:0] count;
    logic          last;
  } exp_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [OW-1:0] m_tdata;
  logic [CW-1:0] m_tcount;
  logic          m_tlast;
  logic [31:0]   match_total;
  logic          overflow;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] model_total = 0;

  cam_result_collector #(
    .C_DATA_WIDTH(DW), .OUT_WIDTH(OW), .FIFO_DEPTH(16), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .areset(areset), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tcount(m_tcount),
    .m_tlast(m_tlast), .match_total(match_total), .overflow(overflow)
  );

  always #5 aclk = ~aclk;

  // Monitor: the negedge sits between input updates (posedge+2) and the handshake edge.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got count=%0d last=%b, expected no word", m_tcount, m_tlast);
      end else begin
        e = sb.pop_front();
        if (m_tdata !== e.data || m_tcount !== e.count || m_tlast !== e.last) begin
          errors++;
          $display("FAIL out_word: got count=%0d last=%b data=%h, expected count=%0d last=%b data=%h",
                   m_tcount, m_tlast, m_tdata, e.count, e.last, e.data);
        end
      end
    end
  end

  task automatic beat(input logic [3:0] st, input logic b);
    s_tvalid = 1'b1;
    s_tdata  = '0;
    s_tdata[DW-1 -: 4] = st;
    s_tdata[0] = b;
    if ((st == 4'h4 || st == 4'h5) && b) model_total++;
    @(posedge aclk); #2;
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge aclk); #2; end
  endtask

  task automatic push_exp(input logic [OW-1:0] d, input logic [CW-1:0] c, input logic l);
    exp_t e;
    e.data = d; e.count = c; e.last = l;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || m_tvalid) && n < 3000) begin
      @(posedge aclk); #2;
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain: got %0d words still expected, m_tvalid=%b; expected empty", name, sb.size(), m_tvalid);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    idle(2);
    checks++;
    if ({m_tvalid, m_tdata, m_tcount, m_tlast, match_total, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b cnt=%0d last=%b total=%0d ovf=%b data!=0:%b, expected all 0",
               m_tvalid, m_tcount, m_tlast, match_total, overflow, |m_tdata);
    end
    areset = 1'b0;
    idle(1);
  endtask

  task automatic test_full_word();
    logic [OW-1:0] d;
    m_tready = 1'b1;
    for (int k = 0; k < OW; k++) d[k] = (k % 3 == 0);
    push_exp(d, CW'(OW), 1'b0);
    for (int i = 0; i < OW; i++) beat(4'h5, (i % 3 == 0));
    checks++;
    if (match_total !== 32'd171) begin
      errors++; $display("FAIL full_total: got %0d expected 171", match_total);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL full_latency1: got m_tvalid=%b expected 0", m_tvalid);
    end
    idle(1);
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++; $display("FAIL full_latency2: got m_tvalid=%b expected 1", m_tvalid);
    end
    drain("full");
  endtask

  task automatic test_eos_partial();
    push_exp(OW'(8'h0D), CW'(5), 1'b1);
    beat(4'h4, 1'b1); beat(4'h4, 1'b0); beat(4'h4, 1'b1);
    beat(4'h2, 1'b1);                     // ignored state code
    beat(4'h4, 1'b1); beat(4'h4, 1'b0);
    beat(4'hF, 1'b0);
    checks++;
    if (match_total !== model_total) begin
      errors++; $display("FAIL eos_total_before: got %0d expected %0d", match_total, model_total);
    end
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL eos_latency1: got m_tvalid=%b expected 0", m_tvalid);
    end
    idle(1);
    model_total = 0;
    checks++;
    if (m_tvalid !== 1'b1) begin
      errors++; $display("FAIL eos_latency2: got m_tvalid=%b expected 1", m_tvalid);
    end
    checks++;
    if (match_total !== 32'd0) begin
      errors++; $display("FAIL eos_total_clear: got %0d expected 0", match_total);
    end
    drain("eos");
  endtask

  task automatic test_empty_eos();
    push_exp('0, '0, 1'b1);
    beat(4'hF, 1'b1);
    drain("empty_eos");
    checks++;
    if (match_total !== 32'd0) begin
      errors++; $display("FAIL empty_eos_total: got %0d expected 0", match_total);
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] d;
    for (int k = 0; k < OW; k++) d[k] = 1'($urandom_range(0, 1));
    push_exp(d, CW'(OW), 1'b0);
    push_exp('0, '0, 1'b1);
    for (int i = 0; i < OW; i++) beat(4'h4, d[i]);
    beat(4'hF, 1'b0);
    model_total = 0;
    drain("b2b");
    checks++;
    if (match_total !== 32'd0) begin
      errors++; $display("FAIL b2b_total: got %0d expected 0", match_total);
    end
  endtask

  task automatic test_overflow();
    m_tready = 1'b0;
    for (int w = 0; w < 17; w++) begin
      if (w < 16) push_exp('1, CW'(OW), 1'b0);
      for (int i = 0; i < OW; i++) beat(4'h4, 1'b1);
    end
    idle(2);
    checks++;
    if (overflow !== 1'b1 || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: got overflow=%b m_tvalid=%b expected 1 1", overflow, m_tvalid);
    end
    checks++;
    if (match_total !== model_total) begin
      errors++; $display("FAIL ovf_total: got %0d expected %0d", match_total, model_total);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (m_tdata !== {OW{1'b1}} || m_tcount !== CW'(OW) || m_tlast !== 1'b0) begin
        errors++; $display("FAIL ovf_stable: got count=%0d last=%b ones=%b expected 512 0 1",
                           m_tcount, m_tlast, &m_tdata);
      end
      idle(1);
    end
    m_tready = 1'b1;
    drain("ovf");
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      push_exp('1, CW'(OW), 1'b0);
      for (int i = 0; i < OW; i++) beat(4'h5, 1'b1);
    end
    for (int i = 0; i < 100; i++) beat(4'h5, 1'b1);
    checks++;
    if (match_total !== model_total || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL mid_before: got total=%0d v=%b expected %0d 1", match_total, m_tvalid, model_total);
    end
    areset = 1'b1;
    idle(1);
    sb.delete();
    model_total = 0;
    checks++;
    if ({m_tvalid, m_tdata, m_tcount, m_tlast, match_total, overflow} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got v=%b cnt=%0d last=%b total=%0d ovf=%b expected all 0",
               m_tvalid, m_tcount, m_tlast, match_total, overflow);
    end
    areset = 1'b0;
    m_tready = 1'b1;
    push_exp(OW'(8'h13), CW'(5), 1'b1);
    beat(4'h4, 1'b1); beat(4'h4, 1'b1); beat(4'h4, 1'b0); beat(4'h4, 1'b0); beat(4'h4, 1'b1);
    beat(4'hF, 1'b0);
    drain("mid");
    idle(3);
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL mid_extra: got m_tvalid=%b expected 0", m_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_eos_partial();
    test_empty_eos();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
